// File: rtl/muldiv_if.sv
// Issue/result bundle between decode/execute and the multiply/divide unit.
// The master drives the op request; the slave returns busy, the result pulse and HI/LO.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [5:0]      aluop;
  logic            is_unsigned;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic [XLEN-1:0] result;
  logic            result_valid;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, aluop, is_unsigned, op_a, op_b,
    input  busy, result, result_valid, hi, lo
  );

  modport slave (
    input  start, aluop, is_unsigned, op_a, op_b,
    output busy, result, result_valid, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit holding architectural HI/LO.
// Fixed-latency multiply; 34-cycle radix-2 restoring divide (setup, 32 iterations, fixup).
//
// state | meaning
// IDLE  | accepting ops; MFHI/MFLO answered here in one cycle
// MUL   | counting down MUL_LATENCY busy cycles, product written on the last
// DIV   | cnt 33 = setup, 32..1 = one quotient bit each, 0 = sign fixup/writeback
module muldiv_unit #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 4
) (
  input  logic     clock,
  input  logic     reset,
  muldiv_if.slave  bus
);
  localparam logic [5:0] MULT_OP       = 6'b000010;
  localparam logic [5:0] DIV_OP        = 6'b000011;
  localparam logic [5:0] MFHI_OP       = 6'b000100;
  localparam logic [5:0] MFLO_OP       = 6'b000101;
  localparam logic [5:0] MUL_PSEUDO_OP = 6'b100010;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            uns_q, uns_d;
  logic            pseudo_q, pseudo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dsr_q, dsr_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;

  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic [XLEN:0]     rem_shift, rem_diff;
  logic              a_neg, b_neg;

  // Low 64 bits of a 64x64 product are exact for both signed and unsigned operands.
  always_comb begin
    a_ext = uns_q ? {{XLEN{1'b0}}, a_q} : {{XLEN{a_q[XLEN-1]}}, a_q};
    b_ext = uns_q ? {{XLEN{1'b0}}, b_q} : {{XLEN{b_q[XLEN-1]}}, b_q};
    prod  = a_ext * b_ext;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    result_d  = result_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    b_d       = b_q;
    uns_d     = uns_q;
    pseudo_d  = pseudo_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    rem_shift = {rem_q, dvd_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, dsr_q};
    a_neg     = ~uns_q & a_q[XLEN-1];
    b_neg     = ~uns_q & b_q[XLEN-1];

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          unique case (bus.aluop)
            MFHI_OP: begin
              result_d = hi_q;
              valid_d  = 1'b1;
            end
            MFLO_OP: begin
              result_d = lo_q;
              valid_d  = 1'b1;
            end
            MULT_OP, MUL_PSEUDO_OP: begin
              a_d      = bus.op_a;
              b_d      = bus.op_b;
              pseudo_d = (bus.aluop == MUL_PSEUDO_OP);
              uns_d    = (bus.aluop == MULT_OP) & bus.is_unsigned;
              cnt_d    = 6'(MUL_LATENCY - 1);
              busy_d   = 1'b1;
              state_d  = MUL;
            end
            DIV_OP: begin
              a_d     = bus.op_a;
              b_d     = bus.op_b;
              uns_d   = bus.is_unsigned;
              cnt_d   = 6'd33;
              busy_d  = 1'b1;
              state_d = DIV;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        if (cnt_q == 6'd0) begin
          if (pseudo_q) begin
            result_d = prod[XLEN-1:0];
            valid_d  = 1'b1;
          end else begin
            {hi_d, lo_d} = prod;
          end
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      DIV: begin
        if (cnt_q == 6'd33) begin
          dvd_d  = a_neg ? -a_q : a_q;
          dsr_d  = b_neg ? -b_q : b_q;
          rem_d  = '0;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          cnt_d  = cnt_q - 6'd1;
        end else if (cnt_q != 6'd0) begin
          // A clear borrow bit means the shifted remainder covered the divisor.
          if (!rem_diff[XLEN]) begin
            rem_d = rem_diff[XLEN-1:0];
            dvd_d = {dvd_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = rem_shift[XLEN-1:0];
            dvd_d = {dvd_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q - 6'd1;
        end else begin
          if (b_q == '0) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = qneg_q ? -dvd_q : dvd_q;
            hi_d = rneg_q ? -rem_q : rem_q;
          end
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      uns_q    <= 1'b0;
      pseudo_q <= 1'b0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      a_q      <= a_d;
      b_q      <= b_d;
      uns_q    <= uns_d;
      pseudo_q <= pseudo_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: MULT/MULTU/MUL/DIV/DIVU, MFHI/MFLO, edge cases,
// ignored issues while busy and reset in the middle of a divide.
module tb_muldiv_unit;
  localparam logic [5:0] MULT_OP       = 6'b000010;
  localparam logic [5:0] DIV_OP        = 6'b000011;
  localparam logic [5:0] MFHI_OP       = 6'b000100;
  localparam logic [5:0] MFLO_OP       = 6'b000101;
  localparam logic [5:0] MUL_PSEUDO_OP = 6'b100010;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   cycles;
  int   pulses;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32), .MUL_LATENCY(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one op; returns at the first negedge with busy=0 after the accept edge.
  task automatic run_op(input logic [5:0] op, input logic uns, input logic [31:0] a,
                        input logic [31:0] b, output int n);
    bus.start       = 1'b1;
    bus.aluop       = op;
    bus.is_unsigned = uns;
    bus.op_a        = a;
    bus.op_b        = b;
    @(negedge clock);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clock);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.aluop = '0;
    bus.is_unsigned = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_valid", 64'(bus.result_valid), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    run_op(MULT_OP, 1'b0, 32'hFFFF_FFFE, 32'd3, cycles);
    chk("mult_cycles", 64'(cycles), 64'd4);
    chk("mult_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("mult_novalid", 64'(bus.result_valid), 64'd0);
    run_op(MFLO_OP, 1'b0, 32'd0, 32'd0, cycles);
    chk("mflo_busy", 64'(cycles), 64'd0);
    chk("mflo_valid", 64'(bus.result_valid), 64'd1);
    chk("mflo_result", 64'(bus.result), 64'h0000_0000_FFFF_FFFA);
    @(negedge clock);
    chk("mflo_pulse", 64'(bus.result_valid), 64'd0);

    run_op(MULT_OP, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cycles);
    chk("multu_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);

    run_op(MUL_PSEUDO_OP, 1'b0, 32'd7, 32'hFFFF_FFFA, cycles);
    chk("mul_cycles", 64'(cycles), 64'd4);
    chk("mul_valid", 64'(bus.result_valid), 64'd1);
    chk("mul_result", 64'(bus.result), 64'h0000_0000_FFFF_FFD6);
    chk("mul_hilo_keep", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    @(negedge clock);
    chk("mul_pulse", 64'(bus.result_valid), 64'd0);

    run_op(DIV_OP, 1'b0, 32'hFFFF_FFF9, 32'd2, cycles);
    chk("div_cycles", 64'(cycles), 64'd34);
    chk("div_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(DIV_OP, 1'b1, 32'd100, 32'd7, cycles);
    chk("divu_hilo", {bus.hi, bus.lo}, {32'd2, 32'd14});

    run_op(DIV_OP, 1'b0, 32'h1234, 32'd0, cycles);
    chk("div0_cycles", 64'(cycles), 64'd34);
    chk("div0_hilo", {bus.hi, bus.lo}, 64'h0000_1234_FFFF_FFFF);

    run_op(DIV_OP, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, cycles);
    chk("divovf_hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

    // DIVU 23/5 with an MFHI attempt and operand churn while busy.
    bus.start = 1'b1;
    bus.aluop = DIV_OP;
    bus.is_unsigned = 1'b1;
    bus.op_a = 32'd23;
    bus.op_b = 32'd5;
    @(negedge clock);
    bus.start = 1'b0;
    bus.op_a = 32'd999;
    bus.op_b = 32'd1;
    bus.is_unsigned = 1'b0;
    cycles = 1;
    pulses = 0;
    repeat (4) begin
      @(negedge clock);
      cycles++;
    end
    bus.start = 1'b1;
    bus.aluop = MFHI_OP;
    @(negedge clock);
    cycles++;
    bus.start = 1'b0;
    chk("busy_hi_keep", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    while (bus.busy && cycles < 100) begin
      if (bus.result_valid) pulses++;
      cycles++;
      @(negedge clock);
    end
    chk("busy_cycles", 64'(cycles - 1), 64'd34);
    chk("busy_no_pulse", 64'(pulses), 64'd0);
    chk("divu2_hilo", {bus.hi, bus.lo}, {32'd3, 32'd4});
    run_op(MFHI_OP, 1'b0, 32'd0, 32'd0, cycles);
    chk("b2b_valid", 64'(bus.result_valid), 64'd1);
    chk("b2b_result", 64'(bus.result), 64'd3);

    // Unknown aluop must be a no-op.
    run_op(6'b111111, 1'b0, 32'd1, 32'd1, cycles);
    chk("bad_op_busy", 64'(cycles), 64'd0);
    chk("bad_op_valid", 64'(bus.result_valid), 64'd0);

    // Reset ten cycles into a divide.
    bus.start = 1'b1;
    bus.aluop = DIV_OP;
    bus.is_unsigned = 1'b0;
    bus.op_a = 32'd1000;
    bus.op_b = 32'd3;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (9) @(negedge clock);
    chk("mid_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("abort_result", 64'(bus.result), 64'd0);
    @(negedge clock);
    chk("abort_idle", 64'(bus.busy), 64'd0);

    run_op(MULT_OP, 1'b0, 32'd3, 32'd5, cycles);
    chk("post_rst_cycles", 64'(cycles), 64'd4);
    chk("post_rst_hilo", {bus.hi, bus.lo}, 64'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle integer multiply/divide unit with architectural HI/LO registers. It is the execute-side responder for the multiply/divide and move-from-HI/LO ops that decode issues as aluop codes. It holds HI/LO and raises busy so the pipeline front end stalls while an operation is in flight. It returns MFHI/MFLO/MUL results on a one-cycle valid pulse.

Parameters:
XLEN, 32, operand/HI/LO width; only 32 is supported.
MUL_LATENCY, 4, cycles busy is held for MULT/MULTU/MUL; legal range 1..15.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  issue strobe; sampled only while busy=0
aluop  input  6  MULT_OP=6'b000010, DIV_OP=6'b000011, MFHI_OP=6'b000100, MFLO_OP=6'b000101, MUL_PSEUDO_OP=6'b100010
is_unsigned  input  1  1 for MULTU/DIVU; ignored for the other ops
op_a  input  32  rs value (dividend / multiplicand)
op_b  input  32  rt value (divisor / multiplier)
busy  output  1  registered; high while MUL or DIV is in progress
result  output  32  MFHI/MFLO/MUL result; holds its value until the next result_valid
result_valid  output  1  one-cycle pulse when result is updated
hi  output  32  architectural HI
lo  output  32  architectural LO

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; hi=lo=result=0; busy=0; result_valid=0; counter=0.
  - Reset has priority over every other event, including mid-operation: any op in flight is aborted and its results are discarded.
- States: IDLE, MUL, DIV.
- Issue: an op is accepted on a clock edge where start=1 and busy=0.
  - start while busy=1 is ignored; decode is responsible for stalling.
  - start with any other aluop value is ignored: no state change, no pulse.
- MFHI_OP / MFLO_OP (IDLE only):
  - result<=hi / lo at the accept edge; result_valid=1 for exactly the following cycle.
  - busy stays 0; latency is 1 cycle.
- MULT_OP (signed or unsigned per is_unsigned):
  - At the accept edge: latch operands, enter MUL, busy<=1.
  - busy is high for exactly MUL_LATENCY cycles.
  - At the edge ending the last busy cycle: {hi,lo}<=64-bit product, busy<=0, state<=IDLE. No result_valid.
- MUL_PSEUDO_OP:
  - Same timing as MULT, signed.
  - hi/lo are NOT modified.
  - result<=product[31:0]; result_valid pulses in the first cycle busy=0.
- DIV_OP: radix-2 restoring division on magnitudes; busy is high for exactly 34 cycles.
  - 1 setup cycle: take absolute values when signed.
  - 32 iteration cycles: one quotient bit per cycle.
  - 1 fixup cycle: sign correction.
  - Then lo<=quotient, hi<=remainder, busy<=0.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divisor=0 (signed or unsigned): lo=32'hFFFFFFFF, hi=op_a; same 34-cycle timing.
  - Signed 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0.
- Back-to-back: in the first cycle busy=0 a new start is accepted. An MFHI/MFLO accepted then returns the freshly written hi/lo.
- Operand capture: op_a/op_b/is_unsigned are sampled only at the accept edge; later changes have no effect.
- hi/lo outputs change only at completion of MULT/DIV or on reset.

Test Plan:
- MULT signed, op_a=32'hFFFFFFFE, op_b=3 -> busy high exactly 4 cycles; then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA. Following MFLO -> result=32'hFFFFFFFA, result_valid high 1 cycle.
- MULTU 32'hFFFFFFFF*32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001. MUL_PSEUDO 7*(-6) -> result=32'hFFFFFFD6 with 1-cycle valid; hi/lo unchanged.
- DIV signed -7/2 -> busy high exactly 34 cycles; lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIV op_a=32'h1234, op_b=0 -> lo=32'hFFFFFFFF, hi=32'h1234. Signed 32'h80000000/32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- start=1 with MFHI during DIV busy -> ignored (no valid, hi/lo unchanged). MFHI issued in the first cycle after busy falls -> returns the new remainder.
- reset asserted at cycle 10 of a DIV -> next cycle busy=0, hi=lo=0, state IDLE. Next MULT 3*5 -> lo=15, hi=0 after 4 busy cycles.
